// File: rtl/key_ce_ctrl_if.sv
// Bundle between the button front-end and its consumer.
// The slave side (key_ce_ctrl) receives the raw pin and returns the CE level and status.
interface key_ce_ctrl_if;
  logic       key_i;
  logic       ce_o;
  logic       press_o;
  logic       pressed_o;
  logic [7:0] press_cnt_o;

  modport master (
    output key_i,
    input  ce_o,
    input  press_o,
    input  pressed_o,
    input  press_cnt_o
  );

  modport slave (
    input  key_i,
    output ce_o,
    output press_o,
    output pressed_o,
    output press_cnt_o
  );
endinterface

// File: rtl/key_ce_ctrl.sv
// Push-button to DQCE clock-enable front-end.
// Two-flop synchroniser, 4-state debounce FSM, registered CE level (toggle or hold),
// one-cycle press strobe and 8-bit press counter. Runs on the ungated board clock.
module key_ce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit INV_BTN         = 1'b1,
  parameter bit TOGGLE          = 1'b1,
  parameter bit CE_RESET        = 1'b1
) (
  input  logic          clk,
  input  logic          rst_i,
  key_ce_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    REL    = 2'd0,
    P_WAIT = 2'd1,
    PRS    = 2'd2,
    R_WAIT = 2'd3
  } state_t;

  // Last count value of a WAIT state; reaching it with a stable key accepts the level.
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_reg;
  logic        key_n;
  state_t      state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic        pressed_reg, pressed_next;
  logic        press_reg, press_next;
  logic        ce_reg, ce_next;
  logic [7:0]  press_cnt_reg, press_cnt_next;

  // Synchroniser stages; they reset to the released pin level so reset never looks like a press.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_i) begin
          if (!rst_i) sync_reg[gi] <= INV_BTN;
          else        sync_reg[gi] <= bus.key_i;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_i) begin
          if (!rst_i) sync_reg[gi] <= INV_BTN;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Normalised key: 1 = pressed, independent of board polarity.
  assign key_n = sync_reg[1] ^ INV_BTN;

  // State, debounce counter and all output flops.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= REL;
      cnt_reg       <= '0;
      pressed_reg   <= 1'b0;
      press_reg     <= 1'b0;
      ce_reg        <= CE_RESET;
      press_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pressed_reg   <= pressed_next;
      press_reg     <= press_next;
      ce_reg        <= ce_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

  // Debounce transitions; the counter restarts on every state change and on any disagreeing sample.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    unique case (state_reg)
      REL: begin
        if (key_n) begin
          state_next = P_WAIT;
          cnt_next   = 20'd1;
        end
      end
      P_WAIT: begin
        if (!key_n) begin
          state_next = REL;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRS;
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end
      PRS: begin
        if (!key_n) begin
          state_next = R_WAIT;
          cnt_next   = 20'd1;
        end
      end
      R_WAIT: begin
        if (key_n) begin
          state_next = PRS;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = REL;
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end
      default: state_next = REL;
    endcase
  end

  // Next values of the registered outputs, so CE never has a combinational path from the pin.
  always_comb begin
    pressed_next   = (state_next == PRS) || (state_next == R_WAIT);
    press_next     = (state_reg == P_WAIT) && (state_next == PRS);
    press_cnt_next = press_cnt_reg + 8'(press_next);
    if (TOGGLE) ce_next = press_next ? ~ce_reg : ce_reg;
    else        ce_next = CE_RESET ^ pressed_next;
  end

  assign bus.ce_o        = ce_reg;
  assign bus.press_o     = press_reg;
  assign bus.pressed_o   = pressed_reg;
  assign bus.press_cnt_o = press_cnt_reg;

endmodule

// File: tb/tb_key_ce_ctrl.sv
// Testbench for key_ce_ctrl: a toggle-mode and a hold-mode instance share one button.
// Press strobes of the toggle instance are checked against a scoreboard of expected
// {cycle, ce, count} entries; directed checks cover reset, bounce and hold-mode levels.
module tb_key_ce_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic key;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  typedef struct {
    int         at;
    logic       ce;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic       ce_exp;
  logic [7:0] cnt_exp;

  key_ce_ctrl_if tog_if();
  key_ce_ctrl_if hold_if();

  assign tog_if.key_i  = key;
  assign hold_if.key_i = key;

  key_ce_ctrl #(.DEBOUNCE_CYCLES(4), .INV_BTN(1'b1), .TOGGLE(1'b1), .CE_RESET(1'b1)) dut_tog (
    .clk   (clk),
    .rst_i (rst_n),
    .bus   (tog_if)
  );

  key_ce_ctrl #(.DEBOUNCE_CYCLES(4), .INV_BTN(1'b1), .TOGGLE(1'b0), .CE_RESET(1'b1)) dut_hold (
    .clk   (clk),
    .rst_i (rst_n),
    .bus   (hold_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input int at);
    exp_t e;
    ce_exp  = ~ce_exp;
    cnt_exp = cnt_exp + 8'd1;
    e.at  = at;
    e.ce  = ce_exp;
    e.cnt = cnt_exp;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    ce_exp  = 1'b1;
    cnt_exp = 8'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ce"},      {31'd0, tog_if.ce_o},       32'd1);
    chk({tag, "_press"},   {31'd0, tog_if.press_o},    32'd0);
    chk({tag, "_pressed"}, {31'd0, tog_if.pressed_o},  32'd0);
    chk({tag, "_cnt"},     {24'd0, tog_if.press_cnt_o}, 32'd0);
    chk({tag, "_hold_ce"}, {31'd0, hold_if.ce_o},      32'd1);
  endtask

  // Monitor: every press strobe pops one expectation; hold instance must always show CE_RESET ^ pressed.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tog_if.press_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("stray_press", 32'(cyc), 32'hFFFFFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("press cyc=%0d ce=%0b cnt=%0d pressed=%0b", cyc, tog_if.ce_o,
                   tog_if.press_cnt_o, tog_if.pressed_o);
          chk("press_cycle",   32'(cyc), 32'(e.at));
          chk("press_ce",      {31'd0, tog_if.ce_o}, {31'd0, e.ce});
          chk("press_cnt",     {24'd0, tog_if.press_cnt_o}, {24'd0, e.cnt});
          chk("press_pressed", {31'd0, tog_if.pressed_o}, 32'd1);
        end
      end
      chk("hold_ce_level", {31'd0, hold_if.ce_o}, {31'd0, ~hold_if.pressed_o});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    key   = 1'b1;
    rst_n = 1'b0;
    model_reset();
    step(3);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(5);

    // Clean press: strobe 6 edges after first sampling edge, ce 1->0, count 1.
    key = 1'b0;
    expect_press(cyc + 6);
    step(20);
    chk("t1_pressed",      {31'd0, tog_if.pressed_o}, 32'd1);
    chk("t1_ce",           {31'd0, tog_if.ce_o},      32'd0);
    chk("t1_cnt",          {24'd0, tog_if.press_cnt_o}, 32'd1);
    chk("t1_hold_ce",      {31'd0, hold_if.ce_o},     32'd0);
    chk("t1_hold_pressed", {31'd0, hold_if.pressed_o}, 32'd1);
    key = 1'b1;
    step(20);
    chk("t1r_pressed", {31'd0, tog_if.pressed_o}, 32'd0);
    chk("t1r_ce",      {31'd0, tog_if.ce_o},      32'd0);
    chk("t1r_hold_ce", {31'd0, hold_if.ce_o},     32'd1);

    // Bounces of 1, 2 and 3 cycles are rejected.
    for (int w = 1; w <= 3; w++) begin
      key = 1'b0;
      step(w);
      key = 1'b1;
      step(2);
    end
    step(10);
    chk("bounce_cnt",     {24'd0, tog_if.press_cnt_o}, 32'd1);
    chk("bounce_ce",      {31'd0, tog_if.ce_o},      32'd0);
    chk("bounce_pressed", {31'd0, tog_if.pressed_o}, 32'd0);

    // Second press with a 2-cycle release glitch while held.
    key = 1'b0;
    expect_press(cyc + 6);
    step(10);
    key = 1'b1;
    step(2);
    key = 1'b0;
    step(10);
    chk("t3_pressed", {31'd0, tog_if.pressed_o}, 32'd1);
    chk("t3_ce",      {31'd0, tog_if.ce_o},      32'd1);
    chk("t3_cnt",     {24'd0, tog_if.press_cnt_o}, 32'd2);
    key = 1'b1;
    step(20);
    chk("t3r_pressed", {31'd0, tog_if.pressed_o}, 32'd0);

    // Reset in the middle of P_WAIT; held button then debounces afresh.
    key = 1'b0;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_pwait");
    model_reset();
    step(1);
    rst_n = 1'b1;
    expect_press(cyc + 6);
    step(10);
    chk("rst_pwait_ce_after", {31'd0, tog_if.ce_o}, 32'd0);

    // Reset in PRS with ce_o=0: asynchronous return to reset values.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_prs");
    model_reset();
    step(1);
    rst_n = 1'b1;
    expect_press(cyc + 6);
    step(10);
    chk("rst_prs_cnt_after", {24'd0, tog_if.press_cnt_o}, 32'd1);
    key = 1'b1;
    step(20);

    // 256 presses from reset: counter wraps to 0 and ce returns to its reset value.
    #2;
    rst_n = 1'b0;
    model_reset();
    step(2);
    rst_n = 1'b1;
    step(5);
    for (int i = 0; i < 256; i++) begin
      key = 1'b0;
      expect_press(cyc + 6);
      step(8);
      key = 1'b1;
      step(8);
    end
    step(5);
    chk("wrap_cnt", {24'd0, tog_if.press_cnt_o}, 32'd0);
    chk("wrap_ce",  {31'd0, tog_if.ce_o},      32'd1);
    chk("sb_empty", 32'(sb.size()),            32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
